// File: rtl/mempool_pkg.sv
// Shared MemPool types for the read-only cache control path: per-cache control
// bundle, rule count and the flush sequencer state encoding.
package mempool_pkg;

  localparam int unsigned ROCacheNumAddrRules = 2;
  localparam int unsigned ROCacheAddrWidth    = 32;

  typedef struct packed {
    logic                                                enable;
    logic                                                flush_valid;
    logic [ROCacheNumAddrRules-1:0][ROCacheAddrWidth-1:0] start_addr;
    logic [ROCacheNumAddrRules-1:0][ROCacheAddrWidth-1:0] end_addr;
  } ro_cache_ctrl_t;

  typedef enum logic [1:0] {
    ROC_IDLE  = 2'd0,
    ROC_FLUSH = 2'd1,
    ROC_APPLY = 2'd2
  } ro_cache_ctrl_state_e;

endpackage

// File: rtl/ro_cache_flush_ctrl.sv
// Sequences configuration changes into the read-only caches: disable + flush all
// caches whenever the rules change (or a flush is forced), then apply atomically.
module ro_cache_flush_ctrl
  import mempool_pkg::*;
#(
  parameter int unsigned NumCaches   = 1,
  parameter int unsigned NrAddrRules = ROCacheNumAddrRules,
  parameter int unsigned AddrWidth   = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  cfg_valid_i,
  output logic                                  cfg_ready_o,
  input  logic                                  cfg_enable_i,
  input  logic                                  cfg_flush_i,
  input  logic [NrAddrRules-1:0][AddrWidth-1:0] cfg_start_addr_i,
  input  logic [NrAddrRules-1:0][AddrWidth-1:0] cfg_end_addr_i,
  output ro_cache_ctrl_t [NumCaches-1:0]        ro_cache_ctrl_o,
  input  logic [NumCaches-1:0]                  flush_ready_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [31:0]                           flush_count_o
);

  if (NumCaches == 0) begin : g_bad_num_caches
    $error("ro_cache_flush_ctrl: NumCaches must be at least 1");
  end
  if (NrAddrRules != ROCacheNumAddrRules || AddrWidth != ROCacheAddrWidth) begin : g_bad_rule_shape
    $error("ro_cache_flush_ctrl: rule shape must match ro_cache_ctrl_t");
  end

  ro_cache_ctrl_state_e r_state, w_state_nxt;

  logic                                  r_sh_enable;
  logic [NrAddrRules-1:0][AddrWidth-1:0] r_sh_start;
  logic [NrAddrRules-1:0][AddrWidth-1:0] r_sh_end;

  logic                                  r_enable;
  logic [NumCaches-1:0]                  r_flush_valid;
  logic [NrAddrRules-1:0][AddrWidth-1:0] r_cur_start;
  logic [NrAddrRules-1:0][AddrWidth-1:0] r_cur_end;
  logic                                  r_done;
  logic [31:0]                           r_flush_count;

  logic                                  w_accept;
  logic                                  w_rules_differ;
  logic                                  w_go_flush;
  logic [NumCaches-1:0]                  w_pending_nxt;
  logic                                  w_flush_last;

  assign cfg_ready_o    = (r_state == ROC_IDLE);
  assign busy_o         = (r_state != ROC_IDLE);
  assign w_accept       = cfg_valid_i && cfg_ready_o;
  assign w_rules_differ = (cfg_start_addr_i != r_cur_start) || (cfg_end_addr_i != r_cur_end);
  assign w_go_flush     = w_accept && (cfg_flush_i || w_rules_differ);
  // Acknowledges on bits that are not outstanding fall out of the mask here.
  assign w_pending_nxt  = r_flush_valid & ~flush_ready_i;
  assign w_flush_last   = (r_state == ROC_FLUSH) && (w_pending_nxt == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ROC_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ROC_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_go_flush ? ROC_FLUSH : ROC_APPLY;
        end
      end
      ROC_FLUSH: begin
        if (w_flush_last) begin
          w_state_nxt = ROC_APPLY;
        end
      end
      ROC_APPLY: w_state_nxt = ROC_IDLE;
      default:   w_state_nxt = ROC_IDLE;
    endcase
  end

  // Shadow command: only meaningful after an accept, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_sh_enable <= cfg_enable_i;
      r_sh_start  <= cfg_start_addr_i;
      r_sh_end    <= cfg_end_addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_enable      <= 1'b0;
      r_flush_valid <= '0;
      r_cur_start   <= '0;
      r_cur_end     <= '0;
      r_done        <= 1'b0;
      r_flush_count <= '0;
    end else begin
      r_done <= (r_state == ROC_APPLY);
      if (w_go_flush) begin
        r_flush_valid <= '1;
        r_enable      <= 1'b0;
      end else if (r_state == ROC_FLUSH) begin
        r_flush_valid <= w_pending_nxt;
        if (w_flush_last) begin
          r_flush_count <= r_flush_count + 32'd1;
        end
      end
      if (r_state == ROC_APPLY) begin
        r_enable    <= r_sh_enable;
        r_cur_start <= r_sh_start;
        r_cur_end   <= r_sh_end;
      end
    end
  end

  // One applied-rule register set fans out to every cache, so all switch together.
  always_comb begin
    for (int i = 0; i < NumCaches; i++) begin
      ro_cache_ctrl_o[i].enable      = r_enable;
      ro_cache_ctrl_o[i].flush_valid = r_flush_valid[i];
      ro_cache_ctrl_o[i].start_addr  = r_cur_start;
      ro_cache_ctrl_o[i].end_addr    = r_cur_end;
    end
  end

  assign done_o        = r_done;
  assign flush_count_o = r_flush_count;

endmodule

// File: doc/ro_cache_flush_ctrl.md
# ro_cache_flush_ctrl

Control-side sequencer for the read-only caches inside the hierarchical AXI interconnect. Accepts configuration commands (enable, address rules, explicit flush) from the control registers and drives one `ro_cache_ctrl_t` per cache instance. Guarantees that new address rules never reach a cache that still holds lines filled under the old rules: it disables the caches, flushes them, waits for every per-cache `flush_ready`, then applies the new configuration atomically to all caches.

## Interface
- `NumCaches`, 1: number of read-only cache instances; 0 is a `$error`.
- `NrAddrRules`, `mempool_pkg::ROCacheNumAddrRules`: cacheable address ranges per cache.
- `AddrWidth`, 32: address width of the rule bounds.
- `clk_i  in  1`: clock. The block has one clock.
- `rst_ni  in  1`: reset, asynchronous and active-low.
- `cfg_valid_i  in  1`: configuration command valid.
- `cfg_ready_o  out  1`: command accepted. High only in IDLE.
- `cfg_enable_i  in  1`: requested cache enable.
- `cfg_flush_i  in  1`: force a flush even if the rules are unchanged.
- `cfg_start_addr_i  in  NrAddrRules×AddrWidth`: rule start addresses.
- `cfg_end_addr_i  in  NrAddrRules×AddrWidth`: rule end addresses.
- `ro_cache_ctrl_o  out  NumCaches×ro_cache_ctrl_t`: per-cache enable, flush_valid, start_addr, end_addr.
- `flush_ready_i  in  NumCaches`: per-cache flush acknowledge.
- `busy_o  out  1`: high in any state other than IDLE.
- `done_o  out  1`: one-cycle pulse when a command completes.
- `flush_count_o  out  32`: number of completed flushes. Wraps modulo 2^32.

## Operation
- States are IDLE, FLUSH and APPLY. All outputs are registered except `cfg_ready_o` and `busy_o`, which are decoded from the state.
- Reset values:
  - state is IDLE.
  - every `enable`, `flush_valid`, `start_addr` and `end_addr` is 0.
  - `done_o` is 0 and `flush_count_o` is 0.
  - `cfg_ready_o` is 1 and `busy_o` is 0.
- IDLE: on `cfg_valid_i && cfg_ready_o`, latch the command into shadow registers.
  - If `cfg_flush_i` is set, or any shadow start/end differs from the currently applied rules, go to FLUSH.
  - Otherwise go to APPLY.
- FLUSH, on entry:
  - Set all `flush_valid` bits and force every `enable` to 0.
  - The flush handshake for cache i completes on `flush_valid[i] && flush_ready_i[i]`; clear `flush_valid[i]` on the next edge.
  - Caches may acknowledge in any order, and several may acknowledge in the same cycle.
  - When the last outstanding bit completes, go to APPLY and increment `flush_count_o`.
- APPLY: copy the shadow rules and `cfg_enable_i` value into every `ro_cache_ctrl_o` entry in the same edge, pulse `done_o`, and return to IDLE.
- Rules differ but the requested enable is 0: a flush still happens, so a later enable never exposes stale lines.
- `flush_ready_i[i]` while `flush_valid[i]` is 0 is ignored.
- There is no timeout. A cache that never acknowledges keeps the block in FLUSH indefinitely.
- Asserting `rst_ni` low mid-FLUSH returns every output to its reset value immediately. The caches are expected to be reset by the same reset.

## Timing
- Command accepted at edge T: `cfg_ready_o` falls and `busy_o` rises in cycle T+1.
- No-flush path: state is APPLY in T+1. New enable and rules are visible, and `done_o` is high, in T+2. `cfg_ready_o` is high again in T+2.
- Flush path:
  - `flush_valid` is high and `enable` low from T+1.
  - If the last acknowledge is seen at edge A, state is APPLY in A+1.
  - New configuration, `done_o` and `cfg_ready_o` are all visible in A+2.
- Minimum flush-path turnaround: an acknowledge in cycle T+1 gives completion in T+3.
- All caches switch configuration on the same edge; there is no skew between entries.

## Structure
- `ro_cache_ctrl_t` and `ROCacheNumAddrRules` stay in `mempool_pkg`.
- Add the state enum `ro_cache_ctrl_state_e` to `mempool_pkg`.
- No sub-module. The rule comparison and the acknowledge mask are local logic.

## Test plan
- Enable-only change:
  - Stimulus: after reset, command enable=1 with rules equal to the reset rules (all 0).
  - Response: no `flush_valid`; `enable` is 1 on every cache 2 cycles after acceptance; `flush_count_o` stays 0.
- Rule change with enable=1, NumCaches=4:
  - Stimulus: rule0=[0x8000_0000,0x8010_0000]; caches acknowledge on cycles +1, +3, +3 and +6.
  - Response: each `flush_valid` drops the cycle after its own acknowledge; `enable` stays 0 throughout.
  - Response: new rules appear 2 cycles after the +6 acknowledge, with one `done_o` pulse and `flush_count_o` = 1.
- Explicit flush:
  - Stimulus: `cfg_flush_i`=1 with unchanged rules.
  - Response: a full flush sequence runs; rules are unchanged afterwards; `flush_count_o` increments.
- Backpressure:
  - Stimulus: hold `cfg_valid_i` high while busy.
  - Response: `cfg_ready_o` stays 0; the second command is accepted only in the `done_o` cycle.
  - Response: `flush_ready_i` pulses while `flush_valid` is 0 have no effect.
- Reset mid-flush:
  - Stimulus: drop `rst_ni` while two caches are still pending.
  - Response: all outputs return to reset values asynchronously; the state is IDLE after reset is released.
- Counter wrap:
  - Stimulus: preload `flush_count_o` to 0xFFFF_FFFF via force, then complete one flush.
  - Response: `flush_count_o` reads 0.
